// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one 256-bit memory port between the I-cache (port 0) and the D-cache (port 1).
// Define MEM_ARB_TIMEOUT_EN to abort a GRANT that sees no mem_ack_i within TIMEOUT_CYCLES (sticky err_o).
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         p0_enable_i,
  input  logic         p0_write_i,
  input  logic [31:0]  p0_addr_i,
  input  logic [255:0] p0_data_i,
  output logic         p0_ack_o,
  output logic [255:0] p0_data_o,
  input  logic         p1_enable_i,
  input  logic         p1_write_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [255:0] p1_data_i,
  output logic         p1_ack_o,
  output logic [255:0] p1_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
  output logic         err_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be within 1..65535");
  end

  logic [1:0]   r_state;
  logic         r_last_grant;
  logic         r_grant;
  logic         r_mem_enable;
  logic         r_mem_write;
  logic [31:0]  r_mem_addr;
  logic [255:0] r_mem_data;
  logic         r_p0_ack;
  logic         r_p1_ack;
  logic [255:0] r_p0_data;
  logic [255:0] r_p1_data;

  logic w_any_req;
  logic w_pick_p1;
  logic w_done;
  logic w_abort;

  assign w_any_req = p0_enable_i | p1_enable_i;
  // On a tie the port that did not win last time is served.
  assign w_pick_p1 = p1_enable_i & (~p0_enable_i | ~r_last_grant);
  assign w_done    = (r_state == S_GRANT) & mem_ack_i;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] r_to_cnt;
  logic        r_to_hit;
  logic        r_err;

  // The limit compare is registered, so the abort lands one cycle after the count reaches the limit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_to_cnt <= '0;
      r_to_hit <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (r_state != S_GRANT) begin
        r_to_cnt <= '0;
        r_to_hit <= 1'b0;
      end else if (!mem_ack_i) begin
        if (r_to_cnt != TIMEOUT_LIMIT) begin
          r_to_cnt <= r_to_cnt + 16'd1;
        end
        r_to_hit <= (r_to_cnt == TIMEOUT_LIMIT);
      end
      if (w_abort) begin
        r_err <= 1'b1;
      end
    end
  end

  assign w_abort = (r_state == S_GRANT) & ~mem_ack_i & r_to_hit;
  assign err_o   = r_err;
`else
  assign w_abort = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_p0_ack     <= 1'b0;
      r_p1_ack     <= 1'b0;
      r_p0_data    <= '0;
      r_p1_data    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state      <= S_GRANT;
            r_grant      <= w_pick_p1;
            r_last_grant <= w_pick_p1;
            r_mem_enable <= 1'b1;
            r_mem_write  <= w_pick_p1 ? p1_write_i : p0_write_i;
            r_mem_addr   <= w_pick_p1 ? p1_addr_i  : p0_addr_i;
            r_mem_data   <= w_pick_p1 ? p1_data_i  : p0_data_i;
          end
        end
        S_GRANT: begin
          if (w_done || w_abort) begin
            r_state      <= S_RESP;
            r_mem_enable <= 1'b0;
            if (r_grant) begin
              r_p1_ack <= 1'b1;
            end else begin
              r_p0_ack <= 1'b1;
            end
            // An aborted transaction leaves the port's read line untouched.
            if (w_done) begin
              if (r_grant) begin
                r_p1_data <= mem_data_i;
              end else begin
                r_p0_data <= mem_data_i;
              end
            end
          end
        end
        S_RESP: begin
          r_state  <= S_IDLE;
          r_p0_ack <= 1'b0;
          r_p1_ack <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign p0_ack_o     = r_p0_ack;
  assign p1_ack_o     = r_p1_ack;
  assign p0_data_o    = r_p0_data;
  assign p1_data_o    = r_p1_data;
  assign mem_enable_o = r_mem_enable;
  assign mem_write_o  = r_mem_write;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus hand sequences, scoreboarded at the memory and ack sides.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         p0_enable, p0_write, p1_enable, p1_write;
  logic [31:0]  p0_addr, p1_addr;
  logic [255:0] p0_data_i, p1_data_i;
  logic         p0_ack_o, p1_ack_o;
  logic [255:0] p0_data_o, p1_data_o;
  logic         mem_enable_o, mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_rdata;
  logic         model_ack, spur_ack;
  logic         mem_ack;
  logic         err_o;

  assign mem_ack = model_ack | spur_ack;

  mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .p0_enable_i(p0_enable), .p0_write_i(p0_write), .p0_addr_i(p0_addr), .p0_data_i(p0_data_i),
    .p0_ack_o(p0_ack_o), .p0_data_o(p0_data_o),
    .p1_enable_i(p1_enable), .p1_write_i(p1_write), .p1_addr_i(p1_addr), .p1_data_i(p1_data_i),
    .p1_ack_o(p1_ack_o), .p1_data_o(p1_data_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_rdata), .mem_ack_i(mem_ack), .err_o(err_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    bit           port;
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] rdata;
  } txn_t;

  typedef struct {
    bit          en0;
    bit          wr0;
    logic [31:0] a0;
    bit          en1;
    bit          wr1;
    logic [31:0] a1;
    int          delay;
  } vec_t;

  txn_t         exp_q[$];
  txn_t         resp_q[$];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           mem_delay = 0;
  int           rise_cnt = 0, rise_cyc = 0, ack_cyc = 0, last_gap = 0;
  int           ack0_cnt = 0, ack1_cnt = 0;
  bit           model_last = 1'b1;
  logic [255:0] model_data [2];

  function automatic logic [255:0] mem_line(input logic [31:0] addr);
    if (addr == 32'h0000_0420) return {32{8'hA5}};
    return {8{addr ^ 32'h5A5A_0000}};
  endfunction

  function automatic logic [255:0] wline(input bit port, input logic [31:0] addr);
    return {8{addr ^ (port ? 32'h0D0D_0000 : 32'h0101_0000)}};
  endfunction

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic flag(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  task automatic push_exp(input bit port, input bit wr, input logic [31:0] addr);
    txn_t t;
    t.port = port; t.wr = wr; t.addr = addr;
    t.wdata = wline(port, addr);
    t.rdata = mem_line(addr);
    exp_q.push_back(t);
    model_data[port] = t.rdata;
    model_last = port;
  endtask

  initial forever @(posedge clk) cyc++;

  // Memory model: acks mem_delay cycles after it first sees the enable; mem_delay < 0 means never.
  initial begin
    bit ok;
    model_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && mem_enable_o && mem_delay >= 0) begin
        ok = 1'b1;
        for (int i = 0; i < mem_delay; i++) begin
          @(negedge clk);
          if (!mem_enable_o || !rst_n) begin
            ok = 1'b0;
            break;
          end
        end
        if (ok) begin
          model_ack = 1'b1;
          mem_rdata = mem_line(mem_addr_o);
          @(negedge clk);
          model_ack = 1'b0;
        end
      end
    end
  end

  // Monitor: checks the command at each grant and the returned line at each ack.
  initial begin
    bit   prev_en, prev_ack0, prev_ack1;
    txn_t t;
    prev_en = 0; prev_ack0 = 0; prev_ack1 = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        prev_en = 0; prev_ack0 = 0; prev_ack1 = 0;
      end else begin
        if (mem_enable_o && !prev_en) begin
          rise_cnt++;
          rise_cyc = cyc;
          last_gap = cyc - ack_cyc;
          if (exp_q.size() == 0) begin
            flag("unexpected_grant", $sformatf("addr %h", mem_addr_o));
          end else begin
            t = exp_q.pop_front();
            check("mem_addr", mem_addr_o, t.addr);
            check("mem_write", mem_write_o, t.wr);
            if (t.wr) check("mem_data", mem_data_o, t.wdata);
            resp_q.push_back(t);
          end
        end
        if (p0_ack_o || p1_ack_o) begin
          ack_cyc = cyc;
          if (p0_ack_o) ack0_cnt++;
          if (p1_ack_o) ack1_cnt++;
          if ((p0_ack_o && prev_ack0) || (p1_ack_o && prev_ack1))
            flag("ack_width", "ack high for more than one cycle");
          check("mem_enable_at_ack", mem_enable_o, 0);
          check("ack_both", p0_ack_o & p1_ack_o, 0);
          if (resp_q.size() == 0) begin
            flag("unexpected_ack", $sformatf("p0_ack=%0b p1_ack=%0b", p0_ack_o, p1_ack_o));
          end else begin
            t = resp_q.pop_front();
            check("ack_port", p1_ack_o, t.port);
            check("read_line", t.port ? p1_data_o : p0_data_o, t.rdata);
            $display("txn port=%0d wr=%0d addr=%h cycle=%0d", t.port, t.wr, t.addr, cyc);
          end
        end
        prev_en = mem_enable_o;
        prev_ack0 = p0_ack_o;
        prev_ack1 = p1_ack_o;
      end
    end
  end

  // Raises a request now (caller is just past a rising edge) and drops it one edge after the ack is seen.
  task automatic drive_req(input bit port, input bit wr, input logic [31:0] addr);
    int n;
    if (port) begin
      p1_enable = 1'b1; p1_write = wr; p1_addr = addr; p1_data_i = wline(1'b1, addr);
    end else begin
      p0_enable = 1'b1; p0_write = wr; p0_addr = addr; p0_data_i = wline(1'b0, addr);
    end
    n = 0;
    while (1) begin
      @(negedge clk);
      if (port ? p1_ack_o : p0_ack_o) break;
      n++;
      if (n > 200) begin
        flag("req_wait", $sformatf("no ack for port %0d within 200 cycles", port));
        break;
      end
    end
    @(posedge clk);
    #1;
    if (port) p1_enable = 1'b0;
    else      p0_enable = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || resp_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain: %0d grants and %0d acks still pending, expected 0", exp_q.size(), resp_q.size());
      exp_q.delete();
      resp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    bit first;
    mem_delay = v.delay;
    if (v.en0 && v.en1) begin
      first = ~model_last;
      if (first) begin
        push_exp(1'b1, v.wr1, v.a1); push_exp(1'b0, v.wr0, v.a0);
      end else begin
        push_exp(1'b0, v.wr0, v.a0); push_exp(1'b1, v.wr1, v.a1);
      end
    end else if (v.en0) begin
      push_exp(1'b0, v.wr0, v.a0);
    end else begin
      push_exp(1'b1, v.wr1, v.a1);
    end
    @(posedge clk);
    #1;
    fork
      begin if (v.en0) drive_req(1'b0, v.wr0, v.a0); end
      begin if (v.en1) drive_req(1'b1, v.wr1, v.a1); end
    join
    wait_drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [5];
    int   n, base, rises0, cnt0;

    vecs[0] = '{en0:0, wr0:0, a0:32'h0,     en1:1, wr1:0, a1:32'h420, delay:10};
    vecs[1] = '{en0:1, wr0:0, a0:32'h100,   en1:1, wr1:1, a1:32'h200, delay:2};
    vecs[2] = '{en0:1, wr0:1, a0:32'h300,   en1:0, wr1:0, a1:32'h0,   delay:0};
    vecs[3] = '{en0:0, wr0:0, a0:32'h0,     en1:1, wr1:0, a1:32'h440, delay:1};
    vecs[4] = '{en0:1, wr0:0, a0:32'h120,   en1:1, wr1:0, a1:32'h220, delay:0};

    rst_n = 1'b0;
    p0_enable = 0; p0_write = 0; p0_addr = '0; p0_data_i = '0;
    p1_enable = 0; p1_write = 0; p1_addr = '0; p1_data_i = '0;
    spur_ack = 1'b0;
    model_data[0] = '0;
    model_data[1] = '0;

    repeat (3) @(negedge clk);
    check("rst_mem_enable", mem_enable_o, 0);
    check("rst_mem_write", mem_write_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_p0_ack", p0_ack_o, 0);
    check("rst_p1_ack", p1_ack_o, 0);
    check("rst_p0_data", p0_data_o, 0);
    check("rst_p1_data", p1_data_o, 0);
    check("rst_err", err_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", mem_enable_o, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Winner re-requests straight away while the loser waits: the loser must be served next.
    mem_delay = 1;
    push_exp(1'b0, 1'b0, 32'h140);
    push_exp(1'b1, 1'b1, 32'h240);
    push_exp(1'b0, 1'b0, 32'h160);
    @(posedge clk);
    #1;
    fork
      begin drive_req(1'b0, 1'b0, 32'h140); drive_req(1'b0, 1'b0, 32'h160); end
      begin drive_req(1'b1, 1'b1, 32'h240); end
    join
    wait_drain();

    // Back-to-back reads on port 0.
    mem_delay = 0;
    push_exp(1'b0, 1'b0, 32'h180);
    push_exp(1'b0, 1'b0, 32'h1A0);
    @(posedge clk);
    #1;
    drive_req(1'b0, 1'b0, 32'h180);
    drive_req(1'b0, 1'b0, 32'h1A0);
    wait_drain();
    check("b2b_gap", last_gap, 2);

    // Spurious memory ack while idle.
    base = ack0_cnt + ack1_cnt;
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("spurious_ack", ack0_cnt + ack1_cnt, base);
    check("spurious_enable", mem_enable_o, 0);

    // Requester drops enable during GRANT.
    mem_delay = 5;
    push_exp(1'b0, 1'b0, 32'h1C0);
    cnt0 = ack0_cnt;
    @(posedge clk);
    #1;
    p0_enable = 1'b1; p0_write = 1'b0; p0_addr = 32'h1C0; p0_data_i = wline(1'b0, 32'h1C0);
    n = 0;
    while (!mem_enable_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    p0_enable = 1'b0;
    wait_drain();
    repeat (2) @(negedge clk);
    check("drop_ack_count", ack0_cnt, cnt0 + 1);

    // Reset in the middle of GRANT.
    mem_delay = 20;
    push_exp(1'b0, 1'b0, 32'h500);
    @(posedge clk);
    #1;
    p0_enable = 1'b1; p0_write = 1'b0; p0_addr = 32'h500; p0_data_i = wline(1'b0, 32'h500);
    n = 0;
    while (!mem_enable_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("midgrant_enable", mem_enable_o, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    p0_enable = 1'b0;
    @(negedge clk);
    check("midrst_enable", mem_enable_o, 0);
    check("midrst_p0_ack", p0_ack_o, 0);
    check("midrst_p1_ack", p1_ack_o, 0);
    check("midrst_err", err_o, 0);
    exp_q.delete();
    resp_q.delete();
    model_last = 1'b1;
    model_data[0] = '0;
    model_data[1] = '0;
    rst_n = 1'b1;
    rises0 = rise_cnt;
    repeat (5) @(negedge clk);
    check("idle_after_midrst", rise_cnt, rises0);
    check("idle_after_midrst_en", mem_enable_o, 0);

    run_vec('{en0:1, wr0:0, a0:32'h620, en1:0, wr1:0, a1:32'h0, delay:3});

`ifdef MEM_ARB_TIMEOUT_EN
    begin
      txn_t t;
      mem_delay = -1;
      t.port = 1'b0; t.wr = 1'b0; t.addr = 32'h600;
      t.wdata = wline(1'b0, 32'h600);
      t.rdata = model_data[0];
      exp_q.push_back(t);
      @(posedge clk);
      #1;
      drive_req(1'b0, 1'b0, 32'h600);
      wait_drain();
      check("timeout_gap", ack_cyc - rise_cyc, 10);
      check("timeout_err", err_o, 1);
      mem_delay = 0;
      repeat (3) @(negedge clk);
      check("timeout_err_sticky", err_o, 1);
    end
`else
    check("err_tied_low", err_o, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
